// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the pipeline memory stage to a word-addressed, asynchronous-read
//   data memory. Loads are lane-selected and sign/zero-extended; word stores
//   write directly; byte/halfword stores are a two-cycle read-modify-write
//   (one stall cycle) because the memory only writes full words.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req, we         access valid / 1=store 0=load
//   funct3          000 b, 001 h, 010 w, 100 bu, 101 hu
//   addr, wdata     byte address, store data
//   rdata           extended load result (0 on a rejected access)
//   stall           hold the memory stage this cycle
//   misaligned      access rejected: not naturally aligned
//   bad_funct3      access rejected: funct3 unsupported for the operation
//   dmem_a/we/wd    word address, write enable, write data to data memory
//   dmem_rd         data memory read data
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        bad_funct3,
  output logic [31:0] dmem_a,
  output logic        dmem_we,
  output logic [31:0] dmem_wd,
  input  logic [31:0] dmem_rd
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] merged_q, merged_d;

  logic        legal;
  logic        align_ok;
  logic        active;
  logic        ok;
  logic [31:0] aligned_a;
  logic [31:0] byte_shift;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] merged;
  logic [4:0]  lane_base;

  always_comb begin
    legal      = 1'b0;
    align_ok   = 1'b1;
    active     = 1'b0;
    ok         = 1'b0;
    aligned_a  = {addr[31:2], 2'b00};
    lane_base  = {addr[1:0], 3'b000};
    byte_shift = dmem_rd >> lane_base;
    lane_b     = byte_shift[7:0];
    lane_h     = addr[1] ? dmem_rd[31:16] : dmem_rd[15:0];
    merged     = dmem_rd;
    rdata      = '0;
    stall      = 1'b0;
    misaligned = 1'b0;
    bad_funct3 = 1'b0;
    dmem_a     = aligned_a;
    dmem_we    = 1'b0;
    dmem_wd    = wdata;
    state_d    = state_q;
    addr_d     = addr_q;
    merged_d   = merged_q;

    if (we) legal = funct3 inside {3'b000, 3'b001, 3'b010};
    else    legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    case (funct3[1:0])
      2'b01:   align_ok = ~addr[0];
      2'b10:   align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase

    // Flags only mean something for a live request in IDLE; the WRITE cycle
    // ignores the request inputs and reset masks everything.
    active     = ~reset && (state_q == IDLE) && req;
    bad_funct3 = active && ~legal;
    misaligned = active && legal && ~align_ok;
    ok         = active && legal && align_ok;

    case (funct3)
      3'b000:  rdata = {{24{lane_b[7]}}, lane_b};
      3'b001:  rdata = {{16{lane_h[15]}}, lane_h};
      3'b010:  rdata = dmem_rd;
      3'b100:  rdata = {24'h0, lane_b};
      3'b101:  rdata = {16'h0, lane_h};
      default: rdata = '0;
    endcase
    if (bad_funct3 || misaligned) rdata = '0;

    if (funct3[1:0] == 2'b00) begin
      merged[lane_base +: 8] = wdata[7:0];
    end else if (addr[1]) begin
      merged[31:16] = wdata[15:0];
    end else begin
      merged[15:0] = wdata[15:0];
    end

    case (state_q)
      IDLE: begin
        if (ok && we) begin
          if (funct3 == 3'b010) begin
            dmem_we = 1'b1;
          end else begin
            stall    = 1'b1;
            addr_d   = aligned_a;
            merged_d = merged;
            state_d  = WRITE;
          end
        end
      end
      WRITE: begin
        dmem_a  = addr_q;
        dmem_wd = merged_q;
        dmem_we = ~reset;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      merged_q <= merged_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misaligned;
  logic        bad_funct3;
  logic [31:0] dmem_a;
  logic        dmem_we;
  logic [31:0] dmem_wd;
  logic [31:0] dmem_rd;

  logic [31:0] mem [64];

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  assign dmem_rd = mem[dmem_a[7:2]];

  always @(posedge clk) begin
    if (dmem_we) mem[dmem_a[7:2]] <= dmem_wd;
  end

  load_store_unit dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .misaligned(misaligned), .bad_funct3(bad_funct3), .dmem_a(dmem_a),
    .dmem_we(dmem_we), .dmem_wd(dmem_wd), .dmem_rd(dmem_rd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; we = w; funct3 = f; addr = a; wdata = d;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        stall;
    logic        mis;
    logic        bad;
    logic        dwe;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs [14];
  int   stalls;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[2]  = 32'h80FF7F01;
    mem[4]  = 32'h11223344;
    mem[12] = 32'h0;

    //          we  f3     addr   wdata        chk rdata         st mis bad dwe wd
    vecs[0]  = '{0, 3'b000, 32'h9, 32'h0,        1, 32'h0000007F, 0, 0, 0, 0, 32'h0};
    vecs[1]  = '{0, 3'b000, 32'hB, 32'h0,        1, 32'hFFFFFF80, 0, 0, 0, 0, 32'h0};
    vecs[2]  = '{0, 3'b100, 32'hB, 32'h0,        1, 32'h00000080, 0, 0, 0, 0, 32'h0};
    vecs[3]  = '{0, 3'b001, 32'hA, 32'h0,        1, 32'hFFFF80FF, 0, 0, 0, 0, 32'h0};
    vecs[4]  = '{0, 3'b101, 32'hA, 32'h0,        1, 32'h000080FF, 0, 0, 0, 0, 32'h0};
    vecs[5]  = '{0, 3'b010, 32'h8, 32'h0,        1, 32'h80FF7F01, 0, 0, 0, 0, 32'h0};
    vecs[6]  = '{0, 3'b000, 32'h8, 32'h0,        1, 32'h00000001, 0, 0, 0, 0, 32'h0};
    vecs[7]  = '{0, 3'b001, 32'h8, 32'h0,        1, 32'h00007F01, 0, 0, 0, 0, 32'h0};
    vecs[8]  = '{0, 3'b010, 32'h6, 32'h0,        1, 32'h0,        0, 1, 0, 0, 32'h0};
    vecs[9]  = '{1, 3'b001, 32'h3, 32'hBEEF,     1, 32'h0,        0, 1, 0, 0, 32'h0};
    vecs[10] = '{1, 3'b100, 32'h8, 32'h55,       1, 32'h0,        0, 0, 1, 0, 32'h0};
    vecs[11] = '{0, 3'b011, 32'h7, 32'h0,        1, 32'h0,        0, 0, 1, 0, 32'h0};
    vecs[12] = '{0, 3'b001, 32'h9, 32'h0,        1, 32'h0,        0, 1, 0, 0, 32'h0};
    vecs[13] = '{1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 32'h0,       0, 0, 0, 1, 32'hDEADBEEF};

    // Reset: outputs masked even with an illegal live request.
    reset = 1'b1;
    drive(1, 1, 3'b100, 32'h6, 32'h0);
    @(negedge clk); #2;
    chk("rst.stall", {31'h0, stall}, 32'h0);
    chk("rst.dmem_we", {31'h0, dmem_we}, 32'h0);
    chk("rst.bad_funct3", {31'h0, bad_funct3}, 32'h0);
    chk("rst.misaligned", {31'h0, misaligned}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Idle: no request.
    drive(0, 1, 3'b000, 32'h17, 32'hFF);
    #2;
    chk("idle.dmem_we", {31'h0, dmem_we}, 32'h0);
    chk("idle.stall", {31'h0, stall}, 32'h0);
    chk("idle.dmem_a", dmem_a, 32'h14);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(1, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      #2;
      if (vecs[i].chk_rd) chk($sformatf("vec%0d.rdata", i), rdata, vecs[i].rdata);
      chk($sformatf("vec%0d.stall", i), {31'h0, stall}, {31'h0, vecs[i].stall});
      chk($sformatf("vec%0d.misaligned", i), {31'h0, misaligned}, {31'h0, vecs[i].mis});
      chk($sformatf("vec%0d.bad_funct3", i), {31'h0, bad_funct3}, {31'h0, vecs[i].bad});
      chk($sformatf("vec%0d.dmem_we", i), {31'h0, dmem_we}, {31'h0, vecs[i].dwe});
      chk($sformatf("vec%0d.dmem_a", i), dmem_a, {vecs[i].addr[31:2], 2'b00});
      if (vecs[i].dwe) chk($sformatf("vec%0d.dmem_wd", i), dmem_wd, vecs[i].wd);
    end
    @(negedge clk);
    drive(0, 0, 3'b000, 32'h0, 32'h0);
    #2;
    chk("sw.mem", mem[8], 32'hDEADBEEF);

    // sb 0xAB @0x12 read-modify-write.
    @(negedge clk);
    drive(1, 1, 3'b000, 32'h12, 32'h000000AB);
    #2;
    chk("sb.c1.stall", {31'h0, stall}, 32'h1);
    chk("sb.c1.dmem_we", {31'h0, dmem_we}, 32'h0);
    @(negedge clk); #2;
    chk("sb.c2.stall", {31'h0, stall}, 32'h0);
    chk("sb.c2.dmem_we", {31'h0, dmem_we}, 32'h1);
    chk("sb.c2.dmem_a", dmem_a, 32'h10);
    chk("sb.c2.dmem_wd", dmem_wd, 32'h11AB3344);
    @(negedge clk);
    drive(0, 0, 3'b000, 32'h0, 32'h0);
    #2;
    chk("sb.mem", mem[4], 32'h11AB3344);

    // sh 0xBEEF @0x12.
    @(negedge clk);
    drive(1, 1, 3'b001, 32'h12, 32'h1234BEEF);
    #2;
    chk("sh.c1.stall", {31'h0, stall}, 32'h1);
    @(negedge clk); #2;
    chk("sh.c2.dmem_we", {31'h0, dmem_we}, 32'h1);
    chk("sh.c2.dmem_wd", dmem_wd, 32'hBEEF3344);
    @(negedge clk);
    drive(0, 0, 3'b000, 32'h0, 32'h0);
    #2;
    chk("sh.mem", mem[4], 32'hBEEF3344);

    // Back-to-back sb 0x01 @0x30, sb 0x02 @0x31.
    stalls = 0;
    @(negedge clk);
    drive(1, 1, 3'b000, 32'h30, 32'h01);
    #2; if (stall) stalls++;
    @(negedge clk); #2; if (stall) stalls++;
    chk("b2b.first.dmem_wd", dmem_wd, 32'h00000001);
    @(negedge clk);
    drive(1, 1, 3'b000, 32'h31, 32'h02);
    #2; if (stall) stalls++;
    @(negedge clk); #2; if (stall) stalls++;
    chk("b2b.second.dmem_wd", dmem_wd, 32'h00000201);
    @(negedge clk);
    drive(0, 0, 3'b000, 32'h0, 32'h0);
    #2;
    chk("b2b.stalls", stalls, 32'd2);
    chk("b2b.mem", mem[12], 32'h00000201);

    // Reset during WRITE of sb 0x55 @0x11 aborts the write.
    @(negedge clk);
    drive(1, 1, 3'b000, 32'h11, 32'h55);
    #2;
    chk("rstmid.c1.stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("rstmid.dmem_we", {31'h0, dmem_we}, 32'h0);
    chk("rstmid.stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 3'b010, 32'h10, 32'h0);
    #2;
    chk("rstmid.mem", mem[4], 32'hBEEF3344);
    chk("rstmid.lw.rdata", rdata, 32'hBEEF3344);
    chk("rstmid.lw.stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    drive(0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
